satatx_framer: RTL and testbench



---
 rtl/satatx_framer_if.sv | 25 ++
 rtl/satatx_framer.sv | 94 +++++++++
 tb/tb_satatx_framer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/satatx_framer_if.sv
// Stream bundle between the TX CRC generator, the framer and the link-layer primitive mux.
// Slave side belongs to the framer; master side belongs to whatever drives and sinks it.
interface satatx_framer_if;
  localparam int unsigned DW = 32;

  logic          S_AXIS_TVALID;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          S_AXIS_TLAST;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TPRIM;
  logic          M_AXIS_TLAST;

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TPRIM, M_AXIS_TLAST
  );

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TPRIM, M_AXIS_TLAST
  );
endinterface

// File: rtl/satatx_framer.sv
// SATA TX framer: scrambles the CRC-appended dword stream and wraps each frame in SOF/EOF.
// Single registered output stage; primitives bypass the scrambler and do not advance it.
module satatx_framer #(
  parameter logic        OPT_SCRAMBLE   = 1'b1,
  parameter logic [15:0] SCRAMBLER_SEED = 16'hFFFF,
  parameter logic        OPT_LOWPOWER   = 1'b1,
  parameter logic [31:0] P_SOF          = 32'h3737_B57C,
  parameter logic [31:0] P_EOF          = 32'hD5D5_B57C
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESET,
  satatx_framer_if.slave axis
);
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned DW     = 32;
  // x^16 + x^15 + x^13 + x^4 + 1, Galois feedback taps
  localparam logic [LFSR_W-1:0] POLY = 16'hA011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_EOF  = 2'd2
  } state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [DW-1:0]     scram;
  logic [DW-1:0]     data_out;
  logic              load_ok;

  assign load_ok            = !axis.M_AXIS_TVALID || axis.M_AXIS_TREADY;
  assign axis.S_AXIS_TREADY = (state == S_DATA) && load_ok;
  assign data_out           = OPT_SCRAMBLE ? (axis.S_AXIS_TDATA ^ scram) : axis.S_AXIS_TDATA;

  // 32 serial LFSR steps per dword; the first output bit lands in scram[0]
  always_comb begin
    lfsr_next = lfsr;
    scram     = '0;
    for (int i = 0; i < int'(DW); i++) begin
      scram[i]  = lfsr_next[LFSR_W-1];
      lfsr_next = {lfsr_next[LFSR_W-2:0], 1'b0} ^ (lfsr_next[LFSR_W-1] ? POLY : '0);
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state              <= S_IDLE;
      lfsr               <= SCRAMBLER_SEED;
      axis.M_AXIS_TVALID <= 1'b0;
      axis.M_AXIS_TDATA  <= '0;
      axis.M_AXIS_TPRIM  <= 1'b0;
      axis.M_AXIS_TLAST  <= 1'b0;
    end else if (load_ok) begin
      // Empty slot unless a beat is loaded below
      axis.M_AXIS_TVALID <= 1'b0;
      if (OPT_LOWPOWER) begin
        axis.M_AXIS_TDATA <= '0;
        axis.M_AXIS_TPRIM <= 1'b0;
        axis.M_AXIS_TLAST <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (axis.S_AXIS_TVALID) begin
            axis.M_AXIS_TVALID <= 1'b1;
            axis.M_AXIS_TDATA  <= P_SOF;
            axis.M_AXIS_TPRIM  <= 1'b1;
            axis.M_AXIS_TLAST  <= 1'b0;
            lfsr               <= SCRAMBLER_SEED;
            state              <= S_DATA;
          end
        end
        S_DATA: begin
          if (axis.S_AXIS_TVALID) begin
            axis.M_AXIS_TVALID <= 1'b1;
            axis.M_AXIS_TDATA  <= data_out;
            axis.M_AXIS_TPRIM  <= 1'b0;
            axis.M_AXIS_TLAST  <= 1'b0;
            lfsr               <= lfsr_next;
            if (axis.S_AXIS_TLAST) state <= S_EOF;
          end
        end
        S_EOF: begin
          axis.M_AXIS_TVALID <= 1'b1;
          axis.M_AXIS_TDATA  <= P_EOF;
          axis.M_AXIS_TPRIM  <= 1'b1;
          axis.M_AXIS_TLAST  <= 1'b1;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_satatx_framer.sv
// Directed bench for satatx_framer: scrambled and unscrambled instances, back-pressure,
// input gaps, back-to-back frames and asynchronous reset mid-frame.
module tb_satatx_framer;
  localparam logic [31:0] P_SOF = 32'h3737_B57C;
  localparam logic [31:0] P_EOF = 32'hD5D5_B57C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = 32'h0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;
  logic        sel = 1'b0;

  logic        s_tready, m_valid, m_prim, m_last;
  logic [31:0] m_data;

  satatx_framer_if if0 ();
  satatx_framer_if if1 ();

  assign if0.S_AXIS_TVALID = s_tvalid;
  assign if0.S_AXIS_TDATA  = s_tdata;
  assign if0.S_AXIS_TLAST  = s_tlast;
  assign if0.M_AXIS_TREADY = m_tready;
  assign if1.S_AXIS_TVALID = s_tvalid;
  assign if1.S_AXIS_TDATA  = s_tdata;
  assign if1.S_AXIS_TLAST  = s_tlast;
  assign if1.M_AXIS_TREADY = m_tready;

  assign s_tready = sel ? if1.S_AXIS_TREADY : if0.S_AXIS_TREADY;
  assign m_valid  = sel ? if1.M_AXIS_TVALID : if0.M_AXIS_TVALID;
  assign m_data   = sel ? if1.M_AXIS_TDATA  : if0.M_AXIS_TDATA;
  assign m_prim   = sel ? if1.M_AXIS_TPRIM  : if0.M_AXIS_TPRIM;
  assign m_last   = sel ? if1.M_AXIS_TLAST  : if0.M_AXIS_TLAST;

  satatx_framer dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .axis         (if0)
  );

  satatx_framer #(.OPT_SCRAMBLE(1'b0)) dut_raw (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .axis         (if1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] in_d[$];
  logic        in_l[$];
  logic [31:0] obs_d[$];
  logic        obs_p[$];
  logic        obs_l[$];
  int          obs_c[$];
  int          acc_c[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference scrambler: returns {next_state, scram_dword}
  function automatic logic [47:0] scram_model(input logic [15:0] st);
    logic [31:0] s;
    logic        fb;
    s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      fb   = st[15];
      s[i] = fb;
      st   = {st[14:0], 1'b0};
      if (fb) st = st ^ 16'hA011;
    end
    return {st, s};
  endfunction

  task automatic clear_q();
    in_d.delete(); in_l.delete();
    obs_d.delete(); obs_p.delete(); obs_l.delete(); obs_c.delete(); acc_c.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Cycle loop: drive at posedge+1, observe at posedge+2
  task automatic run(input int ready_pct, input int valid_pct, input int budget, output int eofs);
    int          idx = 0;
    int          nf = 0;
    bit          pend = 1'b0;
    bit          held = 1'b0;
    logic [34:0] hv = '0;
    eofs = 0;
    foreach (in_l[i]) if (in_l[i]) nf++;
    for (int n = 0; n < budget && eofs < nf; n++) begin
      m_tready = (int'($urandom_range(99)) < ready_pct);
      if (!pend && idx < in_d.size()) pend = (int'($urandom_range(99)) < valid_pct);
      s_tvalid = pend;
      s_tdata  = pend ? in_d[idx] : 32'h0;
      s_tlast  = pend ? in_l[idx] : 1'b0;
      #1;
      if (held) check("hold_stable", 64'({m_valid, m_last, m_prim, m_data}), 64'(hv));
      if (m_valid && m_tready) begin
        obs_d.push_back(m_data); obs_p.push_back(m_prim);
        obs_l.push_back(m_last); obs_c.push_back(cyc);
        if (m_last) eofs++;
      end
      held = m_valid && !m_tready;
      hv   = {m_valid, m_last, m_prim, m_data};
      if (s_tvalid && s_tready) begin
        acc_c.push_back(cyc);
        idx++;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0; m_tready = 1'b1;
  endtask

  task automatic verify(input bit scr, input bit lat);
    logic [33:0] exp_q[$];
    logic [15:0] st;
    logic [47:0] r;
    bit          start;
    int          n;
    int          j;
    st = 16'hFFFF;
    start = 1'b1;
    foreach (in_d[i]) begin
      if (start) begin
        exp_q.push_back({2'b01, P_SOF});
        st = 16'hFFFF;
        start = 1'b0;
      end
      r  = scram_model(st);
      st = r[47:32];
      exp_q.push_back({2'b00, in_d[i] ^ (scr ? r[31:0] : 32'h0)});
      if (in_l[i]) begin
        exp_q.push_back({2'b11, P_EOF});
        start = 1'b1;
      end
    end
    check("beat_count", 64'(obs_d.size()), 64'(exp_q.size()));
    n = (obs_d.size() < exp_q.size()) ? obs_d.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("beat%0d", i), 64'({obs_l[i], obs_p[i], obs_d[i]}), 64'(exp_q[i]));
    if (lat) begin
      j = 0;
      foreach (obs_p[i]) begin
        if (!obs_p[i] && j < acc_c.size()) begin
          check("latency", 64'(obs_c[i] - acc_c[j]), 64'(1));
          j++;
        end
      end
    end
  endtask

  initial begin
    int e;

    do_reset();
    check("reset_out", 64'({m_valid, m_last, m_prim, m_data}), 64'(0));
    check("reset_s_tready", 64'(s_tready), 64'(0));

    // Zero frame, continuous ready
    clear_q();
    in_d = '{32'h0, 32'h0, 32'h0};
    in_l = '{1'b0, 1'b0, 1'b1};
    run(100, 100, 50, e);
    check("zero_frame_eof", 64'(e), 64'(1));
    verify(1'b1, 1'b1);
    if (obs_d.size() >= 5) begin
      check("scram0", 64'(obs_d[1]), 64'(32'hC2D2_768D));
      check("scram1", 64'(obs_d[2]), 64'(32'h1F26_B368));
      check("back_to_back_5", 64'(obs_c[4] - obs_c[0]), 64'(4));
    end
    check("idle_lowpower", 64'({m_valid, m_last, m_prim, m_data}), 64'(0));

    // Two single-dword frames: reseed at every SOF, zero-gap EOF->SOF
    clear_q();
    in_d = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    in_l = '{1'b1, 1'b1};
    run(100, 100, 50, e);
    check("two_frames_eof", 64'(e), 64'(2));
    verify(1'b1, 1'b1);
    if (obs_d.size() >= 6) begin
      check("reseed_f1", 64'(obs_d[1]), 64'(32'h3D2D_8972));
      check("reseed_f2", 64'(obs_d[4]), 64'(32'h3D2D_8972));
      check("eof_sof_gap", 64'(obs_c[3] - obs_c[2]), 64'(1));
    end

    // Unscrambled instance
    sel = 1'b1;
    do_reset();
    clear_q();
    in_d = '{32'h1234_5678};
    in_l = '{1'b1};
    run(100, 100, 50, e);
    check("raw_eof", 64'(e), 64'(1));
    verify(1'b0, 1'b1);
    if (obs_d.size() >= 2) check("raw_data", 64'(obs_d[1]), 64'(32'h1234_5678));
    sel = 1'b0;

    // 64-dword frame under random back-pressure
    do_reset();
    clear_q();
    for (int i = 0; i < 64; i++) begin
      in_d.push_back($urandom);
      in_l.push_back(i == 63);
    end
    run(70, 100, 2000, e);
    check("stall_eof", 64'(e), 64'(1));
    verify(1'b1, 1'b0);

    // Input gaps: output gaps track input, scrambler continues across them
    clear_q();
    for (int i = 0; i < 10; i++) begin
      in_d.push_back($urandom);
      in_l.push_back(i == 9);
    end
    run(100, 60, 500, e);
    check("gap_eof", 64'(e), 64'(1));
    verify(1'b1, 1'b1);

    // Asynchronous reset mid-frame
    clear_q();
    for (int i = 0; i < 8; i++) begin
      in_d.push_back(32'h0);
      in_l.push_back(i == 7);
    end
    m_tready = 1'b1;
    run(100, 100, 4, e);
    check("pre_reset_beats", 64'(obs_d.size()), 64'(3));
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", 64'(m_valid), 64'(0));
    check("async_reset_s_tready", 64'(s_tready), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_q();
    in_d = '{32'h0, 32'h0};
    in_l = '{1'b0, 1'b1};
    run(100, 100, 50, e);
    check("post_reset_eof", 64'(e), 64'(1));
    verify(1'b1, 1'b1);
    if (obs_d.size() >= 2) begin
      check("post_reset_sof", 64'({obs_p[0], obs_d[0]}), 64'({1'b1, P_SOF}));
      check("post_reset_scram0", 64'(obs_d[1]), 64'(32'hC2D2_768D));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
